// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - register map, field limits, vector layout and FSM encoding for the RTC vector transmitter
package rtc_pkg;

    localparam int NUM_FIELDS = 7;

    localparam logic [2:0] ADDR_SEC   = 3'd0;
    localparam logic [2:0] ADDR_MIN   = 3'd1;
    localparam logic [2:0] ADDR_HOUR  = 3'd2;
    localparam logic [2:0] ADDR_DATE  = 3'd3;
    localparam logic [2:0] ADDR_MONTH = 3'd4;
    localparam logic [2:0] ADDR_YEAR  = 3'd5;
    localparam logic [2:0] ADDR_DWK   = 3'd6;
    localparam logic [2:0] ADDR_CTRL  = 3'd7;
    localparam logic [2:0] LAST_FIELD = ADDR_DWK;

    localparam logic [6:0] SEC_MAX   = 7'd59;
    localparam logic [6:0] MIN_MAX   = 7'd59;
    localparam logic [6:0] HOUR_MAX  = 7'd23;
    localparam logic [6:0] DATE_MIN  = 7'd1;
    localparam logic [6:0] DATE_MAX  = 7'd31;
    localparam logic [6:0] MONTH_MIN = 7'd1;
    localparam logic [6:0] MONTH_MAX = 7'd12;
    localparam logic [6:0] YEAR_MAX  = 7'd99;
    localparam logic [6:0] DWK_MAX   = 7'd6;

    localparam int VEC_SEC_LSB   = 0;
    localparam int VEC_MIN_LSB   = 8;
    localparam int VEC_HOUR_LSB  = 16;
    localparam int VEC_DATE_LSB  = 24;
    localparam int VEC_MONTH_LSB = 32;
    localparam int VEC_YEAR_LSB  = 40;
    localparam int VEC_DWK_LSB   = 48;
    localparam int VEC_TOGGLE    = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_CONV  = 2'd2;
    localparam logic [1:0] ST_PACK  = 2'd3;

    function automatic logic field_in_range(input logic [2:0] idx, input logic [6:0] v);
        case (idx)
            ADDR_SEC:   return v <= SEC_MAX;
            ADDR_MIN:   return v <= MIN_MAX;
            ADDR_HOUR:  return v <= HOUR_MAX;
            ADDR_DATE:  return (v >= DATE_MIN) && (v <= DATE_MAX);
            ADDR_MONTH: return (v >= MONTH_MIN) && (v <= MONTH_MAX);
            ADDR_YEAR:  return v <= YEAR_MAX;
            ADDR_DWK:   return v <= DWK_MAX;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [6:0] field_reset_val(input logic [2:0] idx);
        return ((idx == ADDR_DATE) || (idx == ADDR_MONTH)) ? 7'd1 : 7'd0;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// rtl/bin2bcd_serial.sv - 7-bit binary to two-digit BCD, one shift-add-3 step per cycle
module bin2bcd_serial (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] bin,
    output logic [7:0] bcd,
    output logic       done
);

    // {tens, units, remaining binary bits}; the start cycle already performs step 1
    logic [14:0] shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [14:0] src, adj;

    always_comb begin
        src = start ? {8'd0, bin} : shift_q;
        adj = src;
        if (src[10:7] >= 4'd5) adj[10:7] = src[10:7] + 4'd3;
        if (src[14:11] >= 4'd5) adj[14:11] = src[14:11] + 4'd3;

        shift_d = shift_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        if (start || run_q) shift_d = adj << 1;
        if (start) begin
            cnt_d = 3'd1;
            run_d = 1'b1;
        end else if (run_q) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd6) run_d = 1'b0;
        end
    end

    // done marks the 7th cycle; bcd is the result that edge commits
    assign done = run_q && !start && (cnt_q == 3'd6);
    assign bcd  = shift_d[14:7];

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: rtl/rtc_vector_tx.sv
// rtl/rtc_vector_tx.sv - CPU register file, range check, serial BCD conversion and RTC vector packing
module rtc_vector_tx
    import rtc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        busy,
    output logic [64:0] rtc_out,
    output logic        sent
);

    logic [6:0]  field_q  [NUM_FIELDS];
    logic [6:0]  field_d  [NUM_FIELDS];
    logic [7:0]  shadow_q [NUM_FIELDS];
    logic [7:0]  shadow_d [NUM_FIELDS];
    logic [1:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        start_q, start_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        sent_q, sent_d;
    logic [7:0]  dout_q, dout_d;
    logic [64:0] rtc_q, rtc_d;

    logic        all_valid;
    logic [6:0]  conv_bin;
    logic [7:0]  conv_bcd;
    logic        conv_done;
    logic        din_unused;

    assign din_unused = din[7];

    bin2bcd_serial u_conv (
        .clk   (clk),
        .reset (reset),
        .start (start_q),
        .bin   (conv_bin),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    always_comb begin
        all_valid = 1'b1;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            all_valid = all_valid & field_in_range(3'(i), field_q[i]);
        end
        conv_bin = field_q[idx_q];

        state_d = state_q;
        idx_d   = idx_q;
        start_d = 1'b0;
        err_d   = err_q;
        sent_d  = 1'b0;
        rtc_d   = rtc_q;
        dout_d  = dout_q;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            field_d[i]  = field_q[i];
            shadow_d[i] = shadow_q[i];
        end

        if (cs && !we) begin
            dout_d = (addr == ADDR_CTRL) ? {6'b0, err_q, busy_q} : {1'b0, field_q[addr]};
        end

        case (state_q)
            ST_IDLE: begin
                if (cs && we) begin
                    if (addr == ADDR_CTRL) begin
                        if (din[0]) state_d = ST_CHECK;
                    end else begin
                        field_d[addr] = din[6:0];
                    end
                end
            end
            ST_CHECK: begin
                err_d = !all_valid;
                if (all_valid) begin
                    state_d = ST_CONV;
                    idx_d   = '0;
                    start_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                // next field starts the cycle after the previous finishes: 7 fields x 7 cycles
                if (conv_done) begin
                    shadow_d[idx_q] = conv_bcd;
                    if (idx_q == LAST_FIELD) begin
                        state_d = ST_PACK;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        start_d = 1'b1;
                    end
                end
            end
            default: begin
                // valid SEC/HOUR never set the BCD bits that land on the reserved vector bits
                rtc_d = '0;
                rtc_d[VEC_SEC_LSB   +: 8] = shadow_q[ADDR_SEC];
                rtc_d[VEC_MIN_LSB   +: 8] = shadow_q[ADDR_MIN];
                rtc_d[VEC_HOUR_LSB  +: 8] = shadow_q[ADDR_HOUR];
                rtc_d[VEC_DATE_LSB  +: 8] = shadow_q[ADDR_DATE];
                rtc_d[VEC_MONTH_LSB +: 8] = shadow_q[ADDR_MONTH];
                rtc_d[VEC_YEAR_LSB  +: 8] = shadow_q[ADDR_YEAR];
                rtc_d[VEC_DWK_LSB   +: 8] = shadow_q[ADDR_DWK];
                rtc_d[VEC_TOGGLE]         = ~rtc_q[VEC_TOGGLE];
                sent_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            sent_q  <= 1'b0;
            dout_q  <= '0;
            rtc_q   <= '0;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                field_q[i]  <= field_reset_val(3'(i));
                shadow_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            start_q <= start_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            sent_q  <= sent_d;
            dout_q  <= dout_d;
            rtc_q   <= rtc_d;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                field_q[i]  <= field_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign dout    = dout_q;
    assign busy    = busy_q;
    assign rtc_out = rtc_q;
    assign sent    = sent_q;

endmodule

// File: tb/tb_rtc_vector_tx.sv
// tb/tb_rtc_vector_tx.sv - directed bench with a cycle-level behavioural model of the RTC vector transmitter
module tb_rtc_vector_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, we;
    logic [2:0]  addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        busy;
    logic [64:0] rtc_out;
    logic        sent;

    rtc_vector_tx dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .we      (we),
        .addr    (addr),
        .din     (din),
        .dout    (dout),
        .busy    (busy),
        .rtc_out (rtc_out),
        .sent    (sent)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: fields as integers, timing from the fixed commit latency
    int          m_f [7];
    int          lo  [7] = '{0, 0, 0, 1, 1, 0, 0};
    int          hi  [7] = '{59, 59, 23, 31, 12, 99, 6};
    bit          m_err, m_busy, m_ok, m_sent;
    int          m_age;
    logic [64:0] m_vec;
    logic [7:0]  m_dout;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic bit fields_ok();
        for (int i = 0; i < 7; i++) if (m_f[i] < lo[i] || m_f[i] > hi[i]) return 0;
        return 1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_f    = '{0, 0, 0, 1, 1, 0, 0};
            m_err  = 0; m_busy = 0; m_ok = 0; m_sent = 0; m_age = 0;
            m_vec  = '0;
            m_dout = '0;
        end else begin
            if (cs && !we) m_dout = (addr == 3'd7) ? {6'b0, m_err, m_busy} : 8'(m_f[addr]);
            m_sent = 0;
            if (m_busy) begin
                m_age++;
                if (m_age == 1) m_err = !m_ok;
                if (!m_ok && m_age == 1) m_busy = 0;
                if (m_ok && m_age == 51) begin
                    m_vec = {~m_vec[64], 8'h00, to_bcd(m_f[6]), to_bcd(m_f[5]), to_bcd(m_f[4]),
                             to_bcd(m_f[3]), to_bcd(m_f[2]), to_bcd(m_f[1]), to_bcd(m_f[0])};
                    m_sent = 1;
                    m_busy = 0;
                end
            end else if (cs && we) begin
                if (addr == 3'd7) begin
                    if (din[0]) begin
                        m_busy = 1;
                        m_age  = 0;
                        m_ok   = fields_ok();
                    end
                end else begin
                    m_f[addr] = int'(din[6:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", 65'(busy), 65'(m_busy));
            chk("cyc_sent", 65'(sent), 65'(m_sent));
            chk("cyc_rtc_out", rtc_out, m_vec);
            chk("cyc_dout", 65'(dout), 65'(m_dout));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cs = 1; we = 1; addr = a; din = d;
        tick(1);
        cs = 0; we = 0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] v);
        cs = 1; we = 0; addr = a;
        tick(1);
        cs = 0;
        v = dout;
    endtask

    task automatic commit(output int cycles);
        wr(3'd7, 8'h01);
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            tick(1);
        end
    endtask

    int          cyc;
    logic [7:0]  rv;
    logic [64:0] saved;
    int          bad_a [5] = '{0, 3, 3, 4, 6};
    int          bad_v [5] = '{60, 0, 32, 13, 7};
    int          good_v[5] = '{59, 31, 31, 1, 6};
    int          vals  [7] = '{45, 30, 13, 25, 12, 24, 3};

    initial begin
        reset = 1; cs = 0; we = 0; addr = 0; din = 0;
        tick(3);
        chk_en = 1;
        reset = 0;
        tick(1);
        chk("reset_rtc_out", rtc_out, 65'd0);
        chk("reset_busy", 65'(busy), 65'd0);
        rd(3'd7, rv); chk("reset_ctrl", 65'(rv), 65'h00);
        rd(3'd3, rv); chk("reset_date", 65'(rv), 65'd1);
        rd(3'd4, rv); chk("reset_month", 65'(rv), 65'd1);

        for (int i = 0; i < 7; i++) wr(3'(i), 8'(vals[i]));
        commit(cyc);
        chk("c1_busy_cycles", 65'(cyc), 65'd51);
        chk("c1_sent", 65'(sent), 65'd1);
        chk("c1_fields", 65'(rtc_out[55:0]), 65'h03_24_12_25_13_30_45);
        chk("c1_toggle", 65'(rtc_out[64]), 65'd1);
        tick(1);
        chk("c1_sent_end", 65'(sent), 65'd0);

        commit(cyc);
        chk("c2_busy_cycles", 65'(cyc), 65'd51);
        chk("c2_fields", 65'(rtc_out[55:0]), 65'h03_24_12_25_13_30_45);
        chk("c2_toggle", 65'(rtc_out[64]), 65'd0);
        saved = rtc_out;

        wr(3'd2, 8'd24);
        commit(cyc);
        chk("hr24_busy_cycles", 65'(cyc), 65'd1);
        rd(3'd7, rv); chk("hr24_ctrl", 65'(rv), 65'h02);
        chk("hr24_rtc_kept", rtc_out, saved);
        wr(3'd2, 8'd23);
        commit(cyc);
        rd(3'd7, rv); chk("hr23_ctrl", 65'(rv), 65'h00);
        chk("hr23_vec", rtc_out, {1'b1, 64'h00_03_24_12_25_23_30_45});

        wr(3'd7, 8'h01);
        tick(10);
        wr(3'd0, 8'd7);
        wr(3'd7, 8'h01);
        cyc = 0;
        while (busy && cyc < 200) begin cyc++; tick(1); end
        chk("busywr_vec", rtc_out, {1'b0, 64'h00_03_24_12_25_23_30_45});
        tick(5);
        chk("busywr_no_rerun", 65'(busy), 65'd0);
        rd(3'd0, rv); chk("busywr_sec", 65'(rv), 65'd45);

        for (int k = 0; k < 5; k++) begin
            wr(3'(bad_a[k]), 8'(bad_v[k]));
            commit(cyc);
            chk("range_busy_cycles", 65'(cyc), 65'd1);
            rd(3'd7, rv); chk("range_ctrl", 65'(rv), 65'h02);
            wr(3'(bad_a[k]), 8'(good_v[k]));
        end
        wr(3'd1, 8'd59);
        wr(3'd2, 8'd0);
        wr(3'd5, 8'hE3);
        rd(3'd5, rv); chk("bit7_dropped", 65'(rv), 65'd99);
        commit(cyc);
        chk("edge_vec", rtc_out, {1'b1, 64'h00_06_99_01_31_00_59_59});

        wr(3'd7, 8'h01);
        tick(19);
        reset = 1;
        tick(1);
        chk("midrst_busy", 65'(busy), 65'd0);
        chk("midrst_rtc", rtc_out, 65'd0);
        chk("midrst_sent", 65'(sent), 65'd0);
        reset = 0;
        rd(3'd0, rv); chk("midrst_sec", 65'(rv), 65'd0);
        rd(3'd3, rv); chk("midrst_date", 65'(rv), 65'd1);
        tick(60);
        chk("midrst_quiet", rtc_out, 65'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
        $fatal(1);
    end

endmodule
